// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key schedule (128/192/256, chosen per start).
// One 32-bit schedule word is produced per GEN cycle through a single
// four-sbox SubWord path. Every four words form a 128-bit round key,
// which is presented on a valid/ready port that may apply backpressure.
module aes_key_schedule_seq #(
    parameter int          MAX_NK    = 8,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     key_len,
    input  logic [255:0]   key_in,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic [127:0]   rk_data,
    output logic [3:0]     rk_index,
    output logic           rk_last,
    output logic           busy,
    output logic           err
);
    localparam int AW = $clog2(MAX_NK);

    typedef enum logic {S_IDLE, S_GEN} state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            else      p = p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state_q;
    logic [31:0]   win_q [MAX_NK];
    logic [31:0]   asm_q [3];
    logic [5:0]    i_q;
    logic [2:0]    mod_q;
    logic [2:0]    nk_m1_q;
    logic [3:0]    nr_q;
    logic          is8_q;
    logic [7:0]    rcon_q;
    logic          rk_valid_q;
    logic [127:0]  rk_data_q;
    logic [3:0]    rk_index_q;
    logic          rk_last_q;
    logic          busy_q;
    logic          err_q;

    logic [3:0]    nk_sel_s;
    logic [3:0]    nr_sel_s;
    logic          legal_s;
    logic [5:0]    total_s;
    logic [31:0]   oldest_s;
    logic [31:0]   newest_s;
    logic [31:0]   sub_in_s;
    logic [31:0]   sub_out_s;
    logic [31:0]   new_word_s;
    logic          key_phase_s;
    logic          group_end_s;
    logic          gen_en_s;
    logic          complete_s;
    logic          accept_s;

    // Decode requested key length and check it against the window depth
    always_comb begin
        nk_sel_s = 4'd0;
        nr_sel_s = 4'd0;
        case (key_len)
            2'b00:   begin nk_sel_s = 4'd4; nr_sel_s = 4'd10; end
            2'b01:   begin nk_sel_s = 4'd6; nr_sel_s = 4'd12; end
            2'b10:   begin nk_sel_s = 4'd8; nr_sel_s = 4'd14; end
            default: begin nk_sel_s = 4'd0; nr_sel_s = 4'd0;  end
        endcase
        legal_s = (key_len != 2'b11) && (nk_sel_s <= 4'(MAX_NK));
    end

    // Next schedule word; the window's oldest entry is w[i-Nk], newest is w[i-1]
    always_comb begin
        total_s     = {nr_q + 4'd1, 2'b00};
        oldest_s    = win_q[0];
        newest_s    = win_q[nk_m1_q[AW-1:0]];
        sub_in_s    = (mod_q == 3'd0) ? {newest_s[23:0], newest_s[31:24]} : newest_s;
        sub_out_s   = sub_word(sub_in_s);
        key_phase_s = (i_q <= {3'b000, nk_m1_q});
        // During the key phase the window is rotated so it ends up holding w0..w[Nk-1]
        if (key_phase_s) begin
            new_word_s = oldest_s;
        end else if (mod_q == 3'd0) begin
            new_word_s = oldest_s ^ sub_out_s ^ {rcon_q, 24'h000000};
        end else if (is8_q && (mod_q == 3'd4)) begin
            new_word_s = oldest_s ^ sub_out_s;
        end else begin
            new_word_s = oldest_s ^ newest_s;
        end
        group_end_s = (i_q[1:0] == 2'b11);
        accept_s    = rk_valid_q && rk_ready;
        // Only the group-completing word waits for the output register to free up
        gen_en_s    = (state_q == S_GEN) && (i_q < total_s)
                      && !(group_end_s && rk_valid_q && !rk_ready);
        complete_s  = gen_en_s && group_end_s;
    end

    // Control FSM, word window, group assembler and registered round-key port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int j = 0; j < MAX_NK; j++) win_q[j] <= 32'h0;
            for (int j = 0; j < 3; j++)      asm_q[j] <= 32'h0;
            i_q        <= 6'd0;
            mod_q      <= 3'd0;
            nk_m1_q    <= 3'd0;
            nr_q       <= 4'd0;
            is8_q      <= 1'b0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            rk_data_q  <= 128'h0;
            rk_index_q <= 4'd0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (legal_s) begin
                            state_q <= S_GEN;
                            busy_q  <= 1'b1;
                            i_q     <= 6'd0;
                            mod_q   <= 3'd0;
                            rcon_q  <= RCON_INIT;
                            nk_m1_q <= 3'(nk_sel_s - 4'd1);
                            nr_q    <= nr_sel_s;
                            is8_q   <= (key_len == 2'b10);
                            for (int j = 0; j < MAX_NK; j++)
                                win_q[j] <= key_in[255 - 32*j -: 32];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_GEN: begin
                    if (accept_s) begin
                        rk_valid_q <= 1'b0;
                        if (rk_last_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    if (gen_en_s) begin
                        for (int j = 0; j < MAX_NK - 1; j++) win_q[j] <= win_q[j+1];
                        win_q[nk_m1_q[AW-1:0]] <= new_word_s;
                        case (i_q[1:0])
                            2'b00:   asm_q[0] <= new_word_s;
                            2'b01:   asm_q[1] <= new_word_s;
                            2'b10:   asm_q[2] <= new_word_s;
                            default: ;
                        endcase
                        i_q   <= i_q + 6'd1;
                        mod_q <= (mod_q == nk_m1_q) ? 3'd0 : mod_q + 3'd1;
                        if (!key_phase_s && (mod_q == 3'd0)) rcon_q <= xtime(rcon_q);
                        if (complete_s) begin
                            rk_valid_q <= 1'b1;
                            rk_data_q  <= {asm_q[0], asm_q[1], asm_q[2], new_word_s};
                            rk_index_q <= i_q[5:2];
                            rk_last_q  <= (i_q[5:2] == nr_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_index = rk_index_q;
    assign rk_last  = rk_last_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: known-answer schedules,
// random keys with random backpressure, illegal length, start during GEN
// and reset in the middle of a schedule.
module tb_aes_key_schedule_seq;
    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    key_len;
    logic [255:0]  key_in;
    logic          rk_valid;
    logic          rk_ready;
    logic [127:0]  rk_data;
    logic [3:0]    rk_index;
    logic          rk_last;
    logic          busy;
    logic          err;

    int            checks;
    int            failures;
    logic [7:0]    sbox_t [256];
    logic [127:0]  exp_rk [15];
    logic [127:0]  got_rk [15];
    int            exp_nr;

    aes_key_schedule_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rk_last  (rk_last),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] d;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Builds the S-box by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Reference: textbook key expansion over a full word array
    task automatic build_model(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc [11];
        int          nk;
        nk     = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        exp_nr = nk + 6;
        rc[0]  = 8'h00;
        rc[1]  = 8'h01;
        for (int k = 2; k < 11; k++) rc[k] = xt(rc[k-1]);
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (exp_nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = sub_w({t[23:0], t[31:24]}) ^ {rc[i / nk], 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = sub_w(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= exp_nr; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: ready held high; 1: random ready + stray start; 2: reset once round 5 shows
    task automatic run_sched(input logic [255:0] key, input logic [1:0] kl, input int mode);
        int  cyc;
        int  got;
        bit  done;
        build_model(key, kl);
        rk_ready = (mode != 1);
        key_in   = key;
        key_len  = kl;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        got  = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 2000) begin
            if (cyc == 0) check_eq("busy_gen", 128'(busy), 128'd1);
            if (mode == 1 && cyc == 8) check_eq("no_err_in_gen", 128'(err), 128'd0);
            if (mode == 1) begin
                start   = (cyc == 7);
                key_len = 2'd0;
                rk_ready = 1'($urandom_range(0, 1));
            end
            if (rk_valid) begin
                if (got == 0 && mode == 0) check_eq("latency_r0", 128'(cyc), 128'd4);
                check_eq("rk_data", rk_data, exp_rk[got]);
                check_eq("rk_index", 128'(rk_index), 128'(got));
                check_eq("rk_last", 128'(rk_last), 128'(got == exp_nr));
                if (mode == 2 && got == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_eq("rst_outs", {rk_data[123:0], rk_valid, busy, err, rk_last},
                             128'd0);
                    check_eq("rst_index", 128'(rk_index), 128'd0);
                    rst = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        check_eq("post_rst_quiet", 128'({rk_valid, busy}), 128'd0);
                    end
                    return;
                end
                if (rk_ready) begin
                    got_rk[got] = rk_data;
                    got++;
                    if (got > exp_nr) done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("key_count", 128'(got), 128'(exp_nr + 1));
        check_eq("idle_after", 128'({rk_valid, busy}), 128'd0);
    endtask

    initial begin
        logic [255:0] k;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = 256'h0;
        rk_ready = 1'b1;
        build_sbox();
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", 128'({rk_valid, busy, err, rk_last, rk_index}), 128'd0);
        check_eq("reset_data", rk_data, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // AES-128 known answer
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_sched(k, 2'd0, 0);
        check_eq("kat128_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_eq("kat128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192 known answer under random backpressure and a stray start
        k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        run_sched(k, 2'd1, 1);
        check_eq("kat192_r12", got_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

        // AES-256 known answer
        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_sched(k, 2'd2, 0);
        check_eq("kat256_r14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Illegal key length
        key_len = 2'b11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("err_pulse", 128'({err, busy, rk_valid}), 128'b100);
        @(negedge clk);
        check_eq("err_clear", 128'({err, busy, rk_valid}), 128'd0);
        repeat (5) @(negedge clk);
        check_eq("err_quiet", 128'({busy, rk_valid}), 128'd0);

        // Reset at round 5 of a 256 run, then a fresh 128 run
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_sched(k, 2'd2, 2);
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_sched(k, 2'd0, 0);
        check_eq("fresh128_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Random keys and lengths with random backpressure
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_sched(k, 2'($urandom_range(0, 2)), 1);
            repeat (2) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
